// File: rtl/ntt_addr_pkg.sv
// rtl/ntt_addr_pkg.sv - shared types and sizing helpers for the NTT address sequencer
package ntt_addr_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic [0:0] {
    DIR_FWD = 1'b0,
    DIR_INV = 1'b1
  } dir_e;

  localparam int DEF_N         = 256;
  localparam int DEF_NUM_CORES = 8;

  function automatic int chunk_of(input int n, input int cores);
    return n / cores;
  endfunction

  function automatic int beats_of(input int n, input int cores);
    return n / (2 * cores);
  endfunction

  function automatic int stages_of(input int n);
    return $clog2(n) - 1;
  endfunction

  localparam int CHUNK  = chunk_of(DEF_N, DEF_NUM_CORES);
  localparam int BEATS  = beats_of(DEF_N, DEF_NUM_CORES);
  localparam int STAGES = stages_of(DEF_N);

endpackage

// File: rtl/ntt_addr_lane.sv
// rtl/ntt_addr_lane.sv - combinational (top, bottom) address generator for one butterfly core
module ntt_addr_lane
  import ntt_addr_pkg::*;
#(
  parameter int N          = 256,
  parameter int NUM_CORES  = 8,
  parameter int ADDR_WIDTH = $clog2(N),
  parameter int LGW        = $clog2(ADDR_WIDTH) + 1
) (
  input  logic [ADDR_WIDTH-1:0] core_idx,
  input  logic [LGW-1:0]        lg_len,
  input  logic [ADDR_WIDTH-1:0] k,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [ADDR_WIDTH-1:0] addr_b
);

  localparam int LG_CHUNK = $clog2(chunk_of(N, NUM_CORES));

  logic [LGW-1:0]        lg_span;
  logic [LGW-1:0]        lg_g;
  logic [ADDR_WIDTH-1:0] len;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] j;

  always_comb begin
    lg_span = lg_len + LGW'(1);
    // Cores share a butterfly block once a block spans more than one chunk.
    lg_g    = (lg_span > LGW'(LG_CHUNK)) ? (lg_span - LGW'(LG_CHUNK)) : '0;
    len     = ADDR_WIDTH'(1) << lg_len;
    if (lg_g != '0) begin
      base = ((core_idx >> lg_g) << lg_span)
           + ((core_idx & ((ADDR_WIDTH'(1) << lg_g) - ADDR_WIDTH'(1))) << (LG_CHUNK - 1));
    end else begin
      base = core_idx << LG_CHUNK;
    end
    j      = base + ((k >> lg_len) << lg_span) + (k & (len - ADDR_WIDTH'(1)));
    addr_a = j;
    addr_b = j + len;
  end

endmodule

// File: rtl/ntt_addr_seq.sv
// rtl/ntt_addr_seq.sv - sequential NTT butterfly address walker; NTT_ADDR_INTT_EN adds the inverse-order mode port
module ntt_addr_seq
  import ntt_addr_pkg::*;
#(
  parameter int NUM_CORES  = 8,
  parameter int N          = 256,
  parameter int ADDR_WIDTH = $clog2(N)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
`ifdef NTT_ADDR_INTT_EN
  input  logic                                 mode,
`endif
  output logic                                 busy,
  output logic                                 done,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [ADDR_WIDTH-1:0]                stage_len,
  output logic [ADDR_WIDTH-1:0]                beat_idx,
  output logic                                 stage_last,
  output logic [NUM_CORES-1:0][ADDR_WIDTH-1:0] addr_a,
  output logic [NUM_CORES-1:0][ADDR_WIDTH-1:0] addr_b
);

  localparam int                    LGW    = $clog2(ADDR_WIDTH) + 1;
  localparam logic [LGW-1:0]        LG_MAX = LGW'(ADDR_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] K_LAST = ADDR_WIDTH'(beats_of(N, NUM_CORES) - 1);

  state_e                              state_q, state_d;
  dir_e                                dir_q, dir_d;
  logic [LGW-1:0]                      lg_len_q, lg_len_d;
  logic [ADDR_WIDTH-1:0]               k_q, k_d;
  logic                                out_valid_q, out_valid_d;
  logic                                done_q, done_d;
  logic [ADDR_WIDTH-1:0]               stage_len_q, stage_len_d;
  logic [ADDR_WIDTH-1:0]               beat_idx_q, beat_idx_d;
  logic                                stage_last_q, stage_last_d;
  logic [NUM_CORES-1:0][ADDR_WIDTH-1:0] addr_a_q, addr_a_d;
  logic [NUM_CORES-1:0][ADDR_WIDTH-1:0] addr_b_q, addr_b_d;

  logic [ADDR_WIDTH-1:0] lane_a [NUM_CORES];
  logic [ADDR_WIDTH-1:0] lane_b [NUM_CORES];
  dir_e                  start_dir;
  logic                  fire;
  logic                  last_stage;
  logic                  load_out;

`ifdef NTT_ADDR_INTT_EN
  assign start_dir = dir_e'(mode);
`else
  assign start_dir = DIR_FWD;
`endif

  assign fire       = out_valid_q & out_ready;
  assign last_stage = (dir_q == DIR_INV) ? (lg_len_q == LG_MAX) : (lg_len_q == LGW'(1));

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    lg_len_d    = lg_len_q;
    k_d         = k_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    load_out    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          dir_d       = start_dir;
          lg_len_d    = (start_dir == DIR_INV) ? LGW'(1) : LG_MAX;
          k_d         = '0;
          out_valid_d = 1'b1;
          load_out    = 1'b1;
        end
      end
      RUN: begin
        if (fire) begin
          if (k_q == K_LAST) begin
            if (last_stage) begin
              state_d     = IDLE;
              out_valid_d = 1'b0;
              done_d      = 1'b1;
            end else begin
              k_d      = '0;
              lg_len_d = (dir_q == DIR_INV) ? (lg_len_q + LGW'(1)) : (lg_len_q - LGW'(1));
              load_out = 1'b1;
            end
          end else begin
            k_d      = k_q + ADDR_WIDTH'(1);
            load_out = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Lanes see the next-state k/len so the address outputs can be registered.
  for (genvar c = 0; c < NUM_CORES; c++) begin : g_lane
    ntt_addr_lane #(
      .N          (N),
      .NUM_CORES  (NUM_CORES),
      .ADDR_WIDTH (ADDR_WIDTH),
      .LGW        (LGW)
    ) u_lane (
      .core_idx (ADDR_WIDTH'(c)),
      .lg_len   (lg_len_d),
      .k        (k_d),
      .addr_a   (lane_a[c]),
      .addr_b   (lane_b[c])
    );
  end

  always_comb begin
    stage_len_d  = stage_len_q;
    beat_idx_d   = beat_idx_q;
    stage_last_d = stage_last_q;
    addr_a_d     = addr_a_q;
    addr_b_d     = addr_b_q;
    if (load_out) begin
      stage_len_d  = ADDR_WIDTH'(1) << lg_len_d;
      beat_idx_d   = k_d;
      stage_last_d = (k_d == K_LAST);
      for (int c = 0; c < NUM_CORES; c++) begin
        addr_a_d[c] = lane_a[c];
        addr_b_d[c] = lane_b[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dir_q        <= DIR_FWD;
      lg_len_q     <= '0;
      k_q          <= '0;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      stage_len_q  <= '0;
      beat_idx_q   <= '0;
      stage_last_q <= 1'b0;
      addr_a_q     <= '0;
      addr_b_q     <= '0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      lg_len_q     <= lg_len_d;
      k_q          <= k_d;
      out_valid_q  <= out_valid_d;
      done_q       <= done_d;
      stage_len_q  <= stage_len_d;
      beat_idx_q   <= beat_idx_d;
      stage_last_q <= stage_last_d;
      addr_a_q     <= addr_a_d;
      addr_b_q     <= addr_b_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = done_q;
  assign out_valid  = out_valid_q;
  assign stage_len  = stage_len_q;
  assign beat_idx   = beat_idx_q;
  assign stage_last = stage_last_q;
  assign addr_a     = addr_a_q;
  assign addr_b     = addr_b_q;

endmodule

// File: tb/tb_ntt_addr_seq.sv
// tb/tb_ntt_addr_seq.sv - self-checking bench for ntt_addr_seq (inverse runs only with NTT_ADDR_INTT_EN)
module tb_ntt_addr_seq;

  localparam int NC    = 8;
  localparam int NN    = 256;
  localparam int AW    = 8;
  localparam int BEATS = NN / NC / 2;
  localparam int STG   = $clog2(NN) - 1;
  localparam int TOTAL = BEATS * STG;

  logic                       clk;
  logic                       rst_n;
  logic                       start;
`ifdef NTT_ADDR_INTT_EN
  logic                       mode;
`endif
  logic                       busy;
  logic                       done;
  logic                       out_valid;
  logic                       out_ready;
  logic [AW-1:0]              stage_len;
  logic [AW-1:0]              beat_idx;
  logic                       stage_last;
  logic [NC-1:0][AW-1:0]      addr_a;
  logic [NC-1:0][AW-1:0]      addr_b;

  int n_checks = 0;
  int n_fail   = 0;

  int cap_a    [STG][BEATS][NC];
  int cap_b    [STG][BEATS][NC];
  int cap_last [STG][BEATS];

  typedef struct {
    int s;
    int k;
    int c;
    int a;
    int b;
    int last;
  } vec_t;

  vec_t tbl [9];

  ntt_addr_seq #(
    .NUM_CORES  (NC),
    .N          (NN),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
`ifdef NTT_ADDR_INTT_EN
    .mode       (mode),
`endif
    .busy       (busy),
    .done       (done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .stage_len  (stage_len),
    .beat_idx   (beat_idx),
    .stage_last (stage_last),
    .addr_a     (addr_a),
    .addr_b     (addr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string what);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s", what);
    end
  endtask

  // Butterfly i of a stage pairs (j, j+len); core c owns butterflies c*BEATS .. c*BEATS+BEATS-1.
  function automatic int ref_j(input int len, input int k, input int c);
    int i;
    i = c * BEATS + k;
    return (i / len) * 2 * len + (i % len);
  endfunction

  function automatic bit all_zero();
    return !busy && !done && !out_valid && !stage_last && stage_len == '0 &&
           beat_idx == '0 && addr_a == '0 && addr_b == '0;
  endfunction

  // rmode: 0 = always ready, 1 = random ready plus stray start, 2 = 3-cycle stall at beat 5
  task automatic run_xform(input int rmode, input bit inv, input bit capture, input int want_cyc);
    int beats, cyc, stall, s, k, len, bad_c, got_a, want_a;
    bit ok, rdy, prev_stall;
    logic [NC-1:0][AW-1:0] snap_a, snap_b;
    logic [AW-1:0] snap_len, snap_k;
    logic snap_last;
    beats = 0; cyc = 0; stall = 0; prev_stall = 1'b0;
    snap_a = '0; snap_b = '0; snap_len = '0; snap_k = '0; snap_last = 1'b0;
`ifdef NTT_ADDR_INTT_EN
    mode = inv;
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
`ifdef NTT_ADDR_INTT_EN
    mode = ~inv;
`endif
    while (beats < TOTAL && cyc < 4000) begin
      if (prev_stall)
        chk(out_valid && addr_a == snap_a && addr_b == snap_b && stage_len == snap_len &&
            beat_idx == snap_k && stage_last == snap_last,
            $sformatf("hold at beat %0d: valid=%0d len=%0d k=%0d a0=%0d, required valid=1 len=%0d k=%0d a0=%0d",
                      beats, out_valid, stage_len, beat_idx, addr_a[0], snap_len, snap_k, snap_a[0]));
      case (rmode)
        0: rdy = 1'b1;
        1: rdy = ($urandom_range(0, 9) < 7);
        default: begin
          rdy = !(beats == 5 && stall < 3);
          if (!rdy) stall++;
        end
      endcase
      if (rmode == 1) start = 1'($urandom_range(0, 1));
      out_ready = rdy;
      if (out_valid && rdy) begin
        s   = beats / BEATS;
        k   = beats % BEATS;
        len = inv ? (2 << s) : ((NN / 2) >> s);
        ok  = busy && !done && int'(stage_len) == len && int'(beat_idx) == k &&
              int'(stage_last) == int'(k == BEATS - 1);
        bad_c = -1; got_a = 0; want_a = 0;
        for (int c = 0; c < NC; c++) begin
          if (int'(addr_a[c]) != ref_j(len, k, c) || int'(addr_b[c]) != ref_j(len, k, c) + len) begin
            ok = 1'b0;
            if (bad_c < 0) begin
              bad_c = c; got_a = int'(addr_a[c]); want_a = ref_j(len, k, c);
            end
          end
        end
        chk(ok, $sformatf("beat %0d: len=%0d k=%0d last=%0d core%0d a=%0d, required len=%0d k=%0d last=%0d a=%0d",
                          beats, stage_len, beat_idx, stage_last, bad_c, got_a, len, k,
                          int'(k == BEATS - 1), want_a));
        if (capture) begin
          for (int c = 0; c < NC; c++) begin
            cap_a[s][k][c] = int'(addr_a[c]);
            cap_b[s][k][c] = int'(addr_b[c]);
          end
          cap_last[s][k] = int'(stage_last);
        end
        beats++;
      end
      prev_stall = out_valid && !rdy;
      snap_a = addr_a; snap_b = addr_b; snap_len = stage_len; snap_k = beat_idx; snap_last = stage_last;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk(beats == TOTAL, $sformatf("beat count got %0d, required %0d", beats, TOTAL));
    if (want_cyc >= 0)
      chk(cyc == want_cyc, $sformatf("run cycles got %0d, required %0d", cyc, want_cyc));
    chk(done && !busy && !out_valid,
        $sformatf("done cycle got done=%0d busy=%0d valid=%0d, required 1 0 0", done, busy, out_valid));
  endtask

  initial begin
    tbl[0] = '{0, 0, 0, 0, 128, 0};
    tbl[1] = '{0, 0, 1, 16, 144, 0};
    tbl[2] = '{0, 0, 7, 112, 240, 0};
    tbl[3] = '{2, 0, 1, 16, 48, 0};
    tbl[4] = '{2, 0, 2, 64, 96, 0};
    tbl[5] = '{2, 0, 7, 208, 240, 0};
    tbl[6] = '{2, 15, 1, 31, 63, 1};
    tbl[7] = '{6, 5, 3, 105, 107, 0};
    tbl[8] = '{6, 15, 0, 29, 31, 1};

    rst_n = 1'b0; start = 1'b1; out_ready = 1'b1;
`ifdef NTT_ADDR_INTT_EN
    mode = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk(all_zero(), $sformatf("reset cycle %0d: busy=%0d valid=%0d len=%0d a0=%0d, required all 0",
                                i, busy, out_valid, stage_len, addr_a[0]));
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk(!busy && !out_valid, $sformatf("idle after reset busy=%0d valid=%0d, required 0 0", busy, out_valid));

    run_xform(0, 1'b0, 1'b1, TOTAL);
    @(negedge clk);
    chk(!done && !busy, $sformatf("done pulse width: done=%0d busy=%0d, required 0 0", done, busy));

    for (int i = 0; i < 9; i++) begin
      chk(cap_a[tbl[i].s][tbl[i].k][tbl[i].c] == tbl[i].a &&
          cap_b[tbl[i].s][tbl[i].k][tbl[i].c] == tbl[i].b &&
          cap_last[tbl[i].s][tbl[i].k] == tbl[i].last,
          $sformatf("vec %0d (stage %0d k %0d core %0d): got (%0d,%0d) last=%0d, required (%0d,%0d) last=%0d",
                    i, tbl[i].s, tbl[i].k, tbl[i].c, cap_a[tbl[i].s][tbl[i].k][tbl[i].c],
                    cap_b[tbl[i].s][tbl[i].k][tbl[i].c], cap_last[tbl[i].s][tbl[i].k],
                    tbl[i].a, tbl[i].b, tbl[i].last));
    end

    run_xform(2, 1'b0, 1'b0, TOTAL + 3);

    // start in the done cycle is taken immediately
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk(out_valid && busy && !done && beat_idx == '0 && stage_len == AW'(NN / 2) && addr_a[1] == AW'(16),
        $sformatf("restart in done cycle: valid=%0d k=%0d len=%0d a1=%0d, required 1 0 128 16",
                  out_valid, beat_idx, stage_len, addr_a[1]));

    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk(all_zero(), $sformatf("mid-run reset: busy=%0d valid=%0d k=%0d len=%0d, required all 0",
                              busy, out_valid, beat_idx, stage_len));
    rst_n = 1'b1;
    @(negedge clk);

    run_xform(1, 1'b0, 1'b0, -1);
    @(negedge clk);

`ifdef NTT_ADDR_INTT_EN
    run_xform(0, 1'b1, 1'b0, TOTAL);
    @(negedge clk);
    run_xform(1, 1'b1, 1'b0, -1);
    @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
